// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM pipeline register with a main/skid entry pair, flush, bubble-safe
// controls and a saturating back-pressure counter. State advances on the falling edge.
module exe_mem_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_ALUData,
  input  logic [DATA_W-1:0] in_storeData,
  input  logic [REG_AW-1:0] in_writeSrc,
  input  logic [PC_W-1:0]   in_nextPC4,
  input  logic              in_MemWrite,
  input  logic              in_MemRead,
  input  logic              in_RegWrite,
  input  logic [1:0]        in_MemtoReg,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_ALUData,
  output logic [DATA_W-1:0] out_storeData,
  output logic [REG_AW-1:0] out_writeSrc,
  output logic [PC_W-1:0]   out_nextPC4,
  output logic [1:0]        out_MemtoReg,
  output logic              out_MemWrite,
  output logic              out_MemRead,
  output logic              out_RegWrite,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] aluData;
    logic [DATA_W-1:0] storeData;
    logic [REG_AW-1:0] writeSrc;
    logic [PC_W-1:0]   nextPC4;
    logic              memWrite;
    logic              memRead;
    logic              regWrite;
    logic [1:0]        memtoReg;
  } payload_t;

  payload_t         mainQ, skidQ, inPayload;
  logic             mainValid, skidValid;
  logic [CNT_W-1:0] stallCnt;
  logic             inFire, outFire;

  assign inPayload = '{
    aluData:   in_ALUData,
    storeData: in_storeData,
    writeSrc:  in_writeSrc,
    nextPC4:   in_nextPC4,
    memWrite:  in_MemWrite,
    memRead:   in_MemRead,
    regWrite:  in_RegWrite,
    memtoReg:  in_MemtoReg
  };

  // in_ready comes straight from the skid valid flop, so no combinational
  // path runs from out_ready back to the execute stage.
  assign in_ready = ~skidValid;
  assign inFire   = in_valid & in_ready;
  assign outFire  = mainValid & out_ready;

  // NOTE: all state below uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours; blocking here would let M see S's new value.
  always_ff @(negedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      // NOTE: payloads are reset as well because the outputs must read 0 out of reset.
      mainQ     <= '0;
      skidQ     <= '0;
      mainValid <= 1'b0;
      skidValid <= 1'b0;
    end else if (flush) begin
      mainValid <= 1'b0;
      skidValid <= 1'b0;
    end else if (!mainValid || outFire) begin
      if (skidValid) begin
        mainQ     <= skidQ;
        mainValid <= 1'b1;
        skidValid <= inFire;
        if (inFire) skidQ <= inPayload;
      end else begin
        mainValid <= inFire;
        if (inFire) mainQ <= inPayload;
      end
    end else if (inFire) begin
      skidQ     <= inPayload;
      skidValid <= 1'b1;
    end
  end

  always_ff @(negedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      stallCnt <= '0;
    end else if (mainValid && !out_ready && (stallCnt != '1)) begin
      stallCnt <= stallCnt + CNT_W'(1);
    end
  end

  assign out_valid     = mainValid;
  assign out_ALUData   = mainQ.aluData;
  assign out_storeData = mainQ.storeData;
  assign out_writeSrc  = mainQ.writeSrc;
  assign out_nextPC4   = mainQ.nextPC4;
  assign out_MemtoReg  = mainQ.memtoReg;
  // Side-effecting controls are masked so a bubble can never write memory or registers.
  assign out_MemWrite  = mainQ.memWrite & mainValid;
  assign out_MemRead   = mainQ.memRead  & mainValid;
  assign out_RegWrite  = mainQ.regWrite & mainValid;
  assign stall_cnt     = stallCnt;

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Scoreboarded bench for exe_mem_pipe_reg: directed streams, stalls, flushes,
// bubbles, counter saturation (CNT_W=4) and asynchronous reset.
module tb_exe_mem_pipe_reg;

  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic [DATA_W-1:0] aluData;
    logic [DATA_W-1:0] storeData;
    logic [REG_AW-1:0] writeSrc;
    logic [PC_W-1:0]   nextPC4;
    logic              memWrite;
    logic              memRead;
    logic              regWrite;
    logic [1:0]        memtoReg;
  } payload_t;

  logic              CLK = 1'b1;
  logic              RSTn = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_ALUData, out_storeData;
  logic [REG_AW-1:0] out_writeSrc;
  logic [PC_W-1:0]   out_nextPC4;
  logic [1:0]        out_MemtoReg;
  logic              out_MemWrite, out_MemRead, out_RegWrite;
  logic [CNT_W-1:0]  stall_cnt;
  payload_t          inP = '0;

  int compared = 0;
  int mismatched = 0;
  payload_t expQ[$];

  exe_mem_pipe_reg #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ALUData(inP.aluData), .in_storeData(inP.storeData),
    .in_writeSrc(inP.writeSrc), .in_nextPC4(inP.nextPC4),
    .in_MemWrite(inP.memWrite), .in_MemRead(inP.memRead),
    .in_RegWrite(inP.regWrite), .in_MemtoReg(inP.memtoReg),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ALUData(out_ALUData), .out_storeData(out_storeData),
    .out_writeSrc(out_writeSrc), .out_nextPC4(out_nextPC4),
    .out_MemtoReg(out_MemtoReg),
    .out_MemWrite(out_MemWrite), .out_MemRead(out_MemRead),
    .out_RegWrite(out_RegWrite),
    .stall_cnt(stall_cnt)
  );

  // Falling edges at 5, 15, 25, ...; rising edges sit halfway between them.
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic payload_t mkPayload(input int i, input logic mw, input logic rw);
    payload_t p;
    p.aluData   = DATA_W'(i);
    p.storeData = DATA_W'(i * 32'h100 + 32'h7);
    p.writeSrc  = REG_AW'(i + 3);
    p.nextPC4   = PC_W'(32'h0040_0000 + 4 * i);
    p.memWrite  = mw;
    p.memRead   = ~mw;
    p.regWrite  = rw;
    p.memtoReg  = 2'(i);
    return p;
  endfunction

  // Advance past the next active edge, leaving time for outputs to settle.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic drive(input payload_t p, input logic v);
    inP      = p;
    in_valid = v;
  endtask

  // Monitor: a transfer is committed at the next falling edge whenever
  // out_valid & out_ready hold at the rising edge before it.
  initial begin
    payload_t exp;
    forever begin
      @(posedge CLK);
      if (RSTn && out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          check("unexpected_output", {32'h0, out_ALUData}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp = expQ.pop_front();
          check("sb_ALUData",   {32'h0, out_ALUData},   {32'h0, exp.aluData});
          check("sb_storeData", {32'h0, out_storeData}, {32'h0, exp.storeData});
          check("sb_writeSrc",  64'(out_writeSrc),      64'(exp.writeSrc));
          check("sb_nextPC4",   {32'h0, out_nextPC4},   {32'h0, exp.nextPC4});
          check("sb_ctrl", 64'({out_MemWrite, out_MemRead, out_RegWrite, out_MemtoReg}),
                64'({exp.memWrite, exp.memRead, exp.regWrite, exp.memtoReg}));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic doReset();
    RSTn = 1'b0;
    tick(2);
    RSTn = 1'b1;
  endtask

  initial begin
    payload_t p;
    // ---- reset state ----
    tick(2);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready), 64'd1);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst_ALUData",   {32'h0, out_ALUData}, 64'd0);
    check("rst_ctrl", 64'({out_MemWrite, out_MemRead, out_RegWrite, out_MemtoReg}), 64'd0);
    RSTn = 1'b1;

    // ---- streaming at full throughput ----
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      p = mkPayload(i, i[0], 1'b1);
      drive(p, 1'b1);
      expQ.push_back(p);
      tick();
      check("stream_out_valid", 64'(out_valid), 64'd1);
      check("stream_in_ready",  64'(in_ready), 64'd1);
      check("stream_ALUData",   {32'h0, out_ALUData}, 64'(i));
    end
    drive('0, 1'b0);
    tick();
    check("stream_drained", 64'(out_valid), 64'd0);

    // ---- stall, skid fill and drain ----
    out_ready = 1'b0;
    p = mkPayload(32'h10, 1'b0, 1'b1);
    drive(p, 1'b1);
    expQ.push_back(p);
    tick();
    check("stallA_out_valid", 64'(out_valid), 64'd1);
    check("stallA_in_ready",  64'(in_ready), 64'd1);
    p = mkPayload(32'h20, 1'b0, 1'b1);
    drive(p, 1'b1);
    expQ.push_back(p);
    tick();
    check("stallB_in_ready", 64'(in_ready), 64'd0);
    check("stallB_cnt",      64'(stall_cnt), 64'd1);
    drive('0, 1'b0);
    tick(2);
    check("stall_cnt_3",       64'(stall_cnt), 64'd3);
    check("full_hold_ALUData", {32'h0, out_ALUData}, 64'h10);
    check("full_hold_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    check("drain1_ALUData",  {32'h0, out_ALUData}, 64'h20);
    check("drain1_in_ready", 64'(in_ready), 64'd1);
    check("drain1_cnt_hold", 64'(stall_cnt), 64'd3);
    tick();
    check("drain2_out_valid", 64'(out_valid), 64'd0);

    // ---- flush with both entries full ----
    out_ready = 1'b0;
    drive(mkPayload(32'h31, 1'b1, 1'b0), 1'b1);
    tick();
    drive(mkPayload(32'h32, 1'b1, 1'b0), 1'b1);
    tick();
    check("flushfull_MemWrite", 64'(out_MemWrite), 64'd1);
    check("flushfull_in_ready", 64'(in_ready), 64'd0);
    drive(mkPayload(32'hDEAD, 1'b1, 1'b1), 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive('0, 1'b0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_MemWrite",  64'(out_MemWrite), 64'd0);
    check("flush_RegWrite",  64'(out_RegWrite), 64'd0);
    check("flush_in_ready",  64'(in_ready), 64'd1);

    // flush discards an input that would otherwise have been accepted
    drive(mkPayload(32'h33, 1'b1, 1'b0), 1'b1);
    tick();
    drive(mkPayload(32'hBEEF, 1'b0, 1'b1), 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive('0, 1'b0);
    check("flush_in_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    tick(2);
    check("flush_nothing_appears", 64'(out_valid), 64'd0);

    // flush coincident with out_fire: the held entry still transfers
    out_ready = 1'b0;
    p = mkPayload(32'h44, 1'b0, 1'b1);
    drive(p, 1'b1);
    expQ.push_back(p);
    tick();
    drive('0, 1'b0);
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_fire_out_valid", 64'(out_valid), 64'd0);
    check("flush_fire_sb_empty", 64'(expQ.size()), 64'd0);

    // ---- bubble after a RegWrite instruction ----
    p = mkPayload(32'h55, 1'b0, 1'b1);
    drive(p, 1'b1);
    expQ.push_back(p);
    tick();
    check("bubble_pre_RegWrite", 64'(out_RegWrite), 64'd1);
    drive('0, 1'b0);
    tick();
    check("bubble_out_valid", 64'(out_valid), 64'd0);
    check("bubble_RegWrite",  64'(out_RegWrite), 64'd0);
    check("bubble_MemRead",   64'(out_MemRead), 64'd0);
    check("bubble_stale_ALUData", {32'h0, out_ALUData}, 64'h55);

    // ---- stall counter saturation ----
    doReset();
    check("sat_cnt_cleared", 64'(stall_cnt), 64'd0);
    out_ready = 1'b0;
    p = mkPayload(32'h66, 1'b0, 1'b0);
    drive(p, 1'b1);
    expQ.push_back(p);
    tick();
    drive('0, 1'b0);
    check("sat_cnt_0", 64'(stall_cnt), 64'd0);
    tick(10);
    check("sat_cnt_10", 64'(stall_cnt), 64'd10);
    tick(10);
    check("sat_cnt_20", 64'(stall_cnt), 64'd15);
    tick();
    check("sat_cnt_hold", 64'(stall_cnt), 64'd15);

    // ---- asynchronous reset with both entries full ----
    p = mkPayload(32'h77, 1'b1, 1'b0);
    drive(p, 1'b1);
    expQ.push_back(p);
    tick();
    drive('0, 1'b0);
    check("areset_pre_in_ready", 64'(in_ready), 64'd0);
    #3;
    RSTn = 1'b0;
    expQ.delete();
    #1;
    check("areset_out_valid", 64'(out_valid), 64'd0);
    check("areset_in_ready",  64'(in_ready), 64'd1);
    check("areset_stall_cnt", 64'(stall_cnt), 64'd0);
    check("areset_MemWrite",  64'(out_MemWrite), 64'd0);
    tick();
    RSTn = 1'b1;
    out_ready = 1'b1;
    tick(2);
    check("post_reset_idle", 64'(out_valid), 64'd0);
    check("sb_drained", 64'(expQ.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/exe_mem_pipe_reg.md
# exe_mem_pipe_reg

Parametrised EXE→MEM pipeline register with a valid/ready handshake, two-entry skid buffering, flush, and bubble-safe control outputs. It sits between the execute stage (ALU result, forwarded rt data, destination register, PC+4, memory/write-back controls) and the data-memory stage. It allows either stage to stall without combinational ready paths crossing the boundary. It also counts back-pressure cycles for performance analysis.

## Interface
- DATA_W, 32, width of ALU result and store data
- PC_W, 32, width of the PC+4 field
- REG_AW, 5, register-file address width
- CNT_W, 16, width of the stall counter
- CLK  in  1  clock; all state updates on the falling edge
- RSTn  in  1  reset, asynchronous, active-low
- in_valid  in  1  EXE presents a valid instruction
- in_ready  out  1  block can accept; registered, equals !skid_valid
- in_ALUData  in  DATA_W  ALU result / memory address
- in_storeData  in  DATA_W  forwarded rt data for stores
- in_writeSrc  in  REG_AW  destination register
- in_nextPC4  in  PC_W  PC+4 for link writes
- in_MemWrite, in_MemRead, in_RegWrite  in  1 each  controls
- in_MemtoReg  in  2  write-back source select
- flush  in  1  kill all held and incoming instructions
- out_valid  out  1  main entry holds a valid instruction
- out_ready  in  1  MEM stage accepts
- out_ALUData, out_storeData, out_writeSrc, out_nextPC4, out_MemtoReg  out  matching widths  main-entry payload
- out_MemWrite, out_MemRead, out_RegWrite  out  1 each  main-entry control ANDed with out_valid
- stall_cnt  out  CNT_W  saturating count of back-pressure cycles

## Operation
- Two entries: main (M) and skid (S). Each holds the full payload plus a valid bit. Outputs are driven only from M.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Update rules, evaluated at each falling edge in priority order:
  - flush=1: M.valid←0 and S.valid←0. A simultaneous in_fire is discarded. Payload fields are not required to change.
  - Else if M is empty or out_fire:
    - If S is valid, M←S and S.valid←0. Then, if in_fire, S←input.
    - Else, if in_fire, M←input; otherwise M.valid←0.
  - Else (M valid and stalled): if in_fire, S←input.
- By construction, in_fire cannot occur while S is valid, so no entry is ever overwritten and order is preserved.
- Bubble safety: out_MemWrite, out_MemRead, and out_RegWrite are 0 whenever out_valid=0. The payload fields hold stale values and must not be used by consumers while out_valid=0.
- stall_cnt increments by 1 on each falling edge where out_valid=1 and out_ready=0. It saturates at 2^CNT_W−1, is unaffected by flush, and is cleared only by reset.

## Timing
- Reset (RSTn=0, asynchronous): M.valid=0, S.valid=0, all payloads 0, stall_cnt=0. Consequently out_valid=0, all outputs 0, in_ready=1. Release of reset is synchronous to the next falling edge.
- Latency: an input accepted at edge k appears on the outputs (out_valid=1) immediately after edge k if M was empty or fired at k.
- Throughput: 1 instruction per cycle when out_ready is held at 1.
- in_ready is a pure register output: it depends on no input combinationally. It falls after the edge at which S fills and rises after the edge at which S drains.
- Boundaries:
  - Both entries full with out_ready=0: in_ready=0, state holds.
  - Full with out_ready=1: S moves to M, S.valid←0, in_ready=1 after the edge.
  - flush together with out_fire: the MEM-side transfer completes in that cycle, then both entries clear.
  - RSTn asserted mid-stall: both entries are dropped immediately.

## Test plan
- Reset, then stream ALUData=1..8 with out_ready=1 -> out_ALUData=1..8 on consecutive cycles, out_valid continuously 1 from the first edge, in_ready always 1.
- Send A=0x10 with out_ready=0, then B=0x20 -> in_ready=0 after B is accepted, stall_cnt counts 1 per cycle. Raise out_ready -> outputs 0x10 then 0x20, in_ready=1 after the first drain edge.
- Fill both entries with stores (MemWrite=1), then assert flush together with in_valid=1 -> out_valid=0, out_MemWrite=0 and out_RegWrite=0 next cycle, the flushed input never appears, in_ready=1.
- Idle cycle after a valid RegWrite=1 instruction -> out_RegWrite=0 while out_ALUData still shows the stale value.
- Set CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 and stays at 15.
- Assert RSTn=0 between edges with both entries full -> out_valid=0, in_ready=1, stall_cnt=0 immediately, without waiting for a clock edge.
